inst_fetch_decode: RTL and testbench

- Consumer end of the PC-generator interface.
- Accepts one word-address PC per strobe from the PC controller and fetches the instruction over a req/ack instruction-memory port.
- Buffers fetched {pc, instruction} pairs in a small in-order queue.
- Presents the queue head decoded (RV32I fields) to dispatch, and to the PC controller as operatorType/operatorSubType/operatorFlag.
- Back-pressures the PC controller through fetchReady.

---
 rtl/inst_fetch_decode_if.sv | 32 +++
 rtl/inst_fetch_decode.sv | 98 +++++++++
 tb/tb_inst_fetch_decode.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_decode_if.sv
// inst_fetch_decode_if: PC-controller, instruction-memory and dispatch signals of the fetch/decode stage
interface inst_fetch_decode_if #(parameter int ADDRW = 32);
    logic [ADDRW-1:0] pc;
    logic             pcValid;
    logic             fetchReady;
    logic             flush;
    logic             imemReq;
    logic [ADDRW-1:0] imemAddr;
    logic             imemAck;
    logic [31:0]      imemData;
    logic             instValid;
    logic             dispatchReady;
    logic [ADDRW-1:0] instPc;
    logic [6:0]       operatorType;
    logic [2:0]       operatorSubType;
    logic             operatorFlag;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [31:0]      imm;
    logic             illegal;
    modport master (
        output pc, pcValid, flush, imemAck, imemData, dispatchReady,
        input  fetchReady, imemReq, imemAddr, instValid, instPc, operatorType,
               operatorSubType, operatorFlag, rd, rs1, rs2, imm, illegal
    );
    modport slave (
        input  pc, pcValid, flush, imemAck, imemData, dispatchReady,
        output fetchReady, imemReq, imemAddr, instValid, instPc, operatorType,
               operatorSubType, operatorFlag, rd, rs1, rs2, imm, illegal
    );
endinterface

// File: rtl/inst_fetch_decode.sv
// inst_fetch_decode: fetches one instruction per accepted PC, queues {pc, inst} in order and decodes the head
module inst_fetch_decode #(
    parameter int QDEPTH = 4,
    parameter int ADDRW  = 32
) (
    input logic clock,
    input logic resetn,
    inst_fetch_decode_if.slave bus
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;
    state_t           state, state_n;
    logic [ADDRW-1:0] addr, addr_n;
    logic [ADDRW-1:0] pcq [QDEPTH];
    logic [31:0]      iq [QDEPTH];
    logic [PW-1:0]    wp, rp;
    logic [CW-1:0]    count;
    logic             fetch_ready, push, pop, valid, legal;
    logic [31:0]      inst, imm;
    logic [6:0]       op;
    always_comb begin
        state_n = state;
        addr_n = addr;
        fetch_ready = 1'b0;
        case (state)
            IDLE: begin
                fetch_ready = resetn && count < CW'(QDEPTH) && !bus.flush;
                if (bus.pcValid && fetch_ready) begin
                    state_n = REQ;
                    addr_n = bus.pc;
                end
            end
            // an ack in a flush cycle still completes the fetch; its data is simply not pushed
            REQ: state_n = bus.imemAck ? IDLE : bus.flush ? DRAIN : REQ;
            DRAIN: state_n = bus.imemAck ? IDLE : DRAIN;
            default: state_n = IDLE;
        endcase
    end
    assign push = state == REQ && bus.imemAck && !bus.flush;
    assign pop = valid && bus.dispatchReady && !bus.flush;
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            addr <= '0;
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            state <= state_n;
            addr <= addr_n;
            if (bus.flush) begin
                wp <= '0;
                rp <= '0;
                count <= '0;
            end else begin
                if (push) wp <= wp + 1'b1;
                if (pop) rp <= rp + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end
    always_ff @(posedge clock) begin
        if (push) begin
            pcq[wp] <= addr;
            iq[wp] <= bus.imemData;
        end
    end
    assign valid = count != '0;
    assign inst = valid ? iq[rp] : '0;
    assign op = inst[6:0];
    always_comb begin
        imm = '0;
        legal = 1'b1;
        case (op)
            7'b0010011, 7'b0000011, 7'b1100111: imm = {{20{inst[31]}}, inst[31:20]};
            7'b0100011: imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            7'b1100011: imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            7'b0110111, 7'b0010111: imm = {inst[31:12], 12'b0};
            7'b1101111: imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            7'b0110011: imm = '0;
            default: legal = 1'b0;
        endcase
    end
    assign bus.fetchReady = fetch_ready;
    assign bus.imemReq = state != IDLE;
    assign bus.imemAddr = addr;
    assign bus.instValid = valid;
    assign bus.instPc = valid ? pcq[rp] : '0;
    assign bus.operatorType = op;
    assign bus.operatorSubType = inst[14:12];
    assign bus.operatorFlag = inst[30];
    assign bus.rd = inst[11:7];
    assign bus.rs1 = inst[19:15];
    assign bus.rs2 = inst[24:20];
    assign bus.imm = imm;
    assign bus.illegal = valid && !legal;
endmodule

// File: tb/tb_inst_fetch_decode.sv
// tb_inst_fetch_decode: directed fetch/flush/back-pressure vectors with a scoreboard checking every popped head
module tb_inst_fetch_decode;
    typedef logic [127:0] v_t;
    logic clock = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   ack_dly = 0;
    int   wait_cnt = 0;
    v_t   sb [$];
    inst_fetch_decode_if bus ();
    inst_fetch_decode dut (.clock(clock), .resetn(resetn), .bus(bus));
    always #5 clock = ~clock;
    function automatic v_t mk(logic [31:0] p, logic [6:0] t, logic [2:0] s, logic f, logic [4:0] d,
                              logic [4:0] a, logic [4:0] b, logic [31:0] im, logic il);
        return {37'b0, p, t, s, f, d, a, b, im, il};
    endfunction
    function automatic v_t act_now();
        return mk(bus.instPc, bus.operatorType, bus.operatorSubType, bus.operatorFlag,
                  bus.rd, bus.rs1, bus.rs2, bus.imm, bus.illegal);
    endfunction
    function automatic logic [31:0] mem_word(logic [31:0] a);
        case (a)
            32'h10: return 32'h00A00093;
            32'h0:  return 32'hFE209EE3;
            32'h1:  return 32'h0020A423;
            32'h2:  return 32'h123452B7;
            32'h3:  return 32'hFFDFF0EF;
            32'h4:  return 32'h002081B3;
            32'h5:  return 32'hFFF12203;
            32'h6:  return 32'hFFFFFFFF;
            default: return 32'h0;
        endcase
    endfunction
    // hand-decoded expectations for each word in mem_word
    function automatic v_t exp_of(logic [31:0] a);
        case (a)
            32'h10: return mk(32'h10, 7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd10, 32'd10, 1'b0);
            32'h0:  return mk(32'h0, 7'h63, 3'd1, 1'b1, 5'd29, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b0);
            32'h1:  return mk(32'h1, 7'h23, 3'd2, 1'b0, 5'd8, 5'd1, 5'd2, 32'd8, 1'b0);
            32'h2:  return mk(32'h2, 7'h37, 3'd5, 1'b0, 5'd5, 5'd8, 5'd3, 32'h12345000, 1'b0);
            32'h3:  return mk(32'h3, 7'h6F, 3'd7, 1'b1, 5'd1, 5'd31, 5'd29, 32'hFFFFFFFC, 1'b0);
            32'h4:  return mk(32'h4, 7'h33, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
            32'h5:  return mk(32'h5, 7'h03, 3'd2, 1'b1, 5'd4, 5'd2, 5'd31, 32'hFFFFFFFF, 1'b0);
            32'h6:  return mk(32'h6, 7'h7F, 3'd7, 1'b1, 5'd31, 5'd31, 5'd31, 32'd0, 1'b1);
            default: return '0;
        endcase
    endfunction
    task automatic check(input string name, input v_t act, input v_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    // call only at #1 after a rising edge; returns #1 after the accepting edge
    task automatic issue(input logic [31:0] a);
        logic acc;
        int n;
        acc = 1'b0;
        n = 0;
        bus.pc = a;
        bus.pcValid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clock);
            acc = bus.fetchReady;
            @(posedge clock);
            #1;
            n++;
        end
        bus.pcValid = 1'b0;
        if (acc) sb.push_back(exp_of(a));
        else check("accept_timeout", v_t'(0), v_t'(1));
    endtask
    task automatic wait_empty();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        @(posedge clock);
        #1;
        check("drain", {sb.size() == 0, bus.instValid}, {1'b1, 1'b0});
    endtask
    initial begin
        bus.imemAck = 1'b0;
        bus.imemData = '0;
        forever begin
            @(posedge clock);
            #1;
            bus.imemAck = 1'b0;
            if (bus.imemReq) begin
                if (wait_cnt >= ack_dly) begin
                    bus.imemAck = 1'b1;
                    bus.imemData = mem_word(bus.imemAddr);
                    wait_cnt = 0;
                end else wait_cnt++;
            end else wait_cnt = 0;
        end
    end
    always @(negedge clock) begin
        if (resetn && bus.instValid && bus.dispatchReady && !bus.flush) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop_unexpected: got pc %h expected none", bus.instPc);
            end else check("pop", act_now(), sb.pop_front());
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.pc = '0;
        bus.pcValid = 1'b0;
        bus.flush = 1'b0;
        bus.dispatchReady = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset", {bus.imemReq, bus.imemAddr, bus.instValid, bus.fetchReady, bus.illegal, bus.imm},
              v_t'(0));
        resetn = 1'b1;
        @(posedge clock);
        #1;
        // minimum path with a one-cycle ack
        ack_dly = 1;
        bus.dispatchReady = 1'b1;
        issue(32'h10);
        check("req_addr", {bus.imemReq, bus.imemAddr}, {1'b1, 32'h10});
        @(negedge clock);
        @(negedge clock);
        check("lat_early", bus.instValid, 1'b0);
        @(negedge clock);
        check("lat_valid", {bus.instValid, bus.instPc}, {1'b1, 32'h10});
        @(negedge clock);
        check("popped", bus.instValid, 1'b0);
        @(posedge clock);
        #1;
        ack_dly = 0;
        issue(32'h5);
        wait_empty();
        // fill the queue, then one pop lets pc=4 in
        bus.dispatchReady = 1'b0;
        for (int i = 0; i < 4; i++) issue(32'(i));
        bus.pc = 32'h4;
        bus.pcValid = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("full_ready", bus.fetchReady, 1'b0);
        @(posedge clock);
        #1;
        check("full_noreq", bus.imemReq, 1'b0);
        bus.pcValid = 1'b0;
        bus.dispatchReady = 1'b1;
        @(posedge clock);
        #1;
        bus.dispatchReady = 1'b0;
        @(negedge clock);
        check("ready_again", bus.fetchReady, 1'b1);
        @(posedge clock);
        #1;
        issue(32'h4);
        bus.dispatchReady = 1'b1;
        wait_empty();
        // flush while the request waits three cycles for its ack
        ack_dly = 3;
        issue(32'h5);
        bus.flush = 1'b1;
        sb.delete();
        @(posedge clock);
        #1;
        bus.flush = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check("drain_hold", {bus.imemReq, bus.fetchReady, bus.instValid}, {1'b1, 1'b0, 1'b0});
        end
        @(negedge clock);
        check("drain_done", {bus.imemReq, bus.fetchReady, bus.instValid}, {1'b0, 1'b1, 1'b0});
        @(posedge clock);
        #1;
        wait_empty();
        // flush with three entries queued and a simultaneous pop request
        ack_dly = 0;
        bus.dispatchReady = 1'b0;
        issue(32'h10);
        issue(32'h1);
        issue(32'h2);
        @(posedge clock);
        #1;
        @(negedge clock);
        check("q3_valid", bus.instValid, 1'b1);
        @(posedge clock);
        #1;
        bus.dispatchReady = 1'b1;
        bus.flush = 1'b1;
        sb.delete();
        @(posedge clock);
        #1;
        bus.flush = 1'b0;
        bus.dispatchReady = 1'b0;
        @(negedge clock);
        check("flush_empty", {bus.instValid, bus.fetchReady, bus.imemReq}, {1'b0, 1'b1, 1'b0});
        @(posedge clock);
        #1;
        issue(32'h6);
        @(posedge clock);
        #1;
        @(negedge clock);
        check("illegal_head", act_now(), exp_of(32'h6));
        @(posedge clock);
        #1;
        bus.dispatchReady = 1'b1;
        wait_empty();
        // reset in the middle of a fetch drops the request at once
        ack_dly = 5;
        issue(32'h1);
        #1;
        resetn = 1'b0;
        #1;
        check("async_drop", {bus.imemReq, bus.imemAddr, bus.fetchReady}, v_t'(0));
        sb.delete();
        @(posedge clock);
        #1;
        resetn = 1'b1;
        @(posedge clock);
        #1;
        ack_dly = 0;
        issue(32'h10);
        wait_empty();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
